ps2_scancode_decoder: RTL and testbench

PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

---
 rtl/ps2_scancode_decoder.sv | 219 +++++++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
//   Turns a stream of PS/2 set-2 scan-code bytes into key events
//   {code, ext, release}, queued in a small FIFO for a ready/valid consumer.
//   Also tracks whether a (non-extended) shift key is currently held down.
//
//   Optional feature: define PS2_ASCII_EN to add the ev_ascii output. The
//   ASCII value is computed when the event is pushed, using the shift state
//   as it was before that event.
//
// Parameters
//   FIFO_DEPTH   event FIFO entries (power of two, >= 2)
//   TIMEOUT_CYC  idle cycles after which a pending E0/F0 prefix is abandoned
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   rx_data      scan-code byte, qualified by the one-cycle strobe rx_valid
//   ev_valid     FIFO non-empty; head event on ev_code/ev_ext/ev_release
//   ev_ready     consumer accept; pops the head when ev_valid is high
//   shift_held   left (12) or right (59) shift currently down
//   overflow     sticky flag, an event was dropped on a full FIFO
//   ev_ascii     (PS2_ASCII_EN only) ASCII of the head event, 00 if none
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_release,
  output logic       shift_held,
  output logic       overflow
`ifdef PS2_ASCII_EN
  ,
  output logic [7:0] ev_ascii
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

`ifdef PS2_ASCII_EN
  localparam int ENTRY_W = 18;
`else
  localparam int ENTRY_W = 10;
`endif

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  // Host/keyboard protocol bytes that never form part of a key event.
  function automatic logic is_ctrl(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_ctrl = 1'b1;
      default:                                                is_ctrl = 1'b0;
    endcase
  endfunction

`ifdef PS2_ASCII_EN
  function automatic logic [7:0] to_ascii(input logic [7:0] code,
                                          input logic ext, input logic rel,
                                          input logic shift);
    logic [7:0] a;
    a = 8'h00;
    case (code)
      8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
      8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
      8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
      8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
      8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
      8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
      8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
      8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
      8'h3E: a = 8'h38; 8'h46: a = 8'h39;
      8'h29: a = 8'h20;
      8'h5A: a = 8'h0D;
      default: a = 8'h00;
    endcase
    // Only letters have a shifted form.
    if (shift && a >= 8'h61 && a <= 8'h7A) a = a - 8'h20;
    if (ext || rel) a = 8'h00;
    to_ascii = a;
  endfunction
`endif

  state_t           state, state_nx;
  logic [TO_W-1:0]  to_cnt;
  logic             push, push_ext, push_rel;
  logic [7:0]       push_code;
  logic [ENTRY_W-1:0] push_entry;

  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               full, pop, accept;
  logic [ENTRY_W-1:0] head;
  logic               lshift, rshift;

  // Decode: next state and the event (if any) generated by this byte.
  always_comb begin
    state_nx  = state;
    push      = 1'b0;
    push_code = rx_data;
    push_ext  = 1'b0;
    push_rel  = 1'b0;
    if (rx_valid) begin
      if (is_ctrl(rx_data)) begin
        state_nx = IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (rx_data == 8'hE0)      state_nx = EXT;
            else if (rx_data == 8'hF0) state_nx = BRK;
            else                       push = 1'b1;
          end
          EXT: begin
            if (rx_data == 8'hF0)      state_nx = EXT_BRK;
            else if (rx_data == 8'hE0) state_nx = EXT;
            else begin
              push     = 1'b1;
              push_ext = 1'b1;
              state_nx = IDLE;
            end
          end
          BRK: begin
            push     = 1'b1;
            push_rel = 1'b1;
            state_nx = IDLE;
          end
          EXT_BRK: begin
            push     = 1'b1;
            push_ext = 1'b1;
            push_rel = 1'b1;
            state_nx = IDLE;
          end
          default: state_nx = IDLE;
        endcase
      end
    end else if (state != IDLE && to_cnt == TO_LAST) begin
      state_nx = IDLE;
    end
  end

`ifdef PS2_ASCII_EN
  assign push_entry = {to_ascii(push_code, push_ext, push_rel, shift_held),
                       push_rel, push_ext, push_code};
`else
  assign push_entry = {push_rel, push_ext, push_code};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      to_cnt <= '0;
    end else begin
      state <= state_nx;
      if (rx_valid || state_nx == IDLE) to_cnt <= '0;
      else                              to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign full   = (count == FULL_CNT);
  assign pop    = ev_valid && ev_ready;
  assign accept = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (accept) fifo_mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  // Shift tracking follows every generated event, even one the FIFO drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      lshift <= 1'b0;
      rshift <= 1'b0;
    end else if (push && !push_ext) begin
      if (push_code == 8'h12) lshift <= !push_rel;
      if (push_code == 8'h59) rshift <= !push_rel;
    end
  end

  assign shift_held = lshift || rshift;

  // Head fields are forced to zero while empty so storage needs no reset.
  assign ev_valid   = (count != '0);
  assign head       = fifo_mem[rd_ptr];
  assign ev_code    = ev_valid ? head[7:0] : 8'h00;
  assign ev_ext     = ev_valid && head[8];
  assign ev_release = ev_valid && head[9];
`ifdef PS2_ASCII_EN
  assign ev_ascii   = ev_valid ? head[17:10] : 8'h00;
`endif

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
`timescale 1ns/1ps
module tb_ps2_scancode_decoder;

  localparam int DEPTH = 8;
  localparam int TO    = 40;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic [7:0] ascii;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       ev_ready = 1'b0;
  logic       ev_valid, ev_ext, ev_release, shift_held, overflow;
  logic [7:0] ev_code;
`ifdef PS2_ASCII_EN
  logic [7:0] ev_ascii;
`endif

  int checks = 0;
  int failures = 0;
  ev_t exp_q[$];

  ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
    .ev_ext(ev_ext), .ev_release(ev_release), .shift_held(shift_held),
    .overflow(overflow)
`ifdef PS2_ASCII_EN
    , .ev_ascii(ev_ascii)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one byte for one cycle; returns at the negedge after the capture edge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic expect_ev(input logic [7:0] c, input logic x, input logic r,
                           input logic [7:0] a);
    ev_t e;
    e.code = c; e.ext = x; e.rel = r; e.ascii = a;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ev_valid, ev_code, ev_ext, ev_release, shift_held, overflow} !== 13'h0) begin
      failures++;
      $display("FAIL reset_hold: got %h expected 0000",
               {ev_valid, ev_code, ev_ext, ev_release, shift_held, overflow});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ev_valid, ev_code, ev_ext, ev_release, shift_held, overflow} !== 13'h0) begin
      failures++;
      $display("FAIL reset_release: got %h expected 0000",
               {ev_valid, ev_code, ev_ext, ev_release, shift_held, overflow});
    end
  endtask

  task automatic test_make_break();
    ev_t e;
    do_reset();
    ev_ready = 1'b1;
    expect_ev(8'h1C, 1'b0, 1'b0, 8'h00);
    send(8'h1C);
    e = exp_q.pop_front();
    checks++;
    if ({ev_valid, ev_code, ev_ext, ev_release} !== {1'b1, e.code, e.ext, e.rel}) begin
      failures++;
      $display("FAIL make_1c: got %h expected %h",
               {ev_valid, ev_code, ev_ext, ev_release}, {1'b1, e.code, e.ext, e.rel});
    end
    send(8'hF0);
    checks++;
    if (ev_valid !== 1'b0) begin
      failures++;
      $display("FAIL f0_no_event: got ev_valid=%b expected 0", ev_valid);
    end
    expect_ev(8'h1C, 1'b0, 1'b1, 8'h00);
    send(8'h1C);
    e = exp_q.pop_front();
    checks++;
    if ({ev_valid, ev_code, ev_ext, ev_release} !== {1'b1, e.code, e.ext, e.rel}) begin
      failures++;
      $display("FAIL break_1c: got %h expected %h",
               {ev_valid, ev_code, ev_ext, ev_release}, {1'b1, e.code, e.ext, e.rel});
    end
  endtask

  task automatic test_extended();
    logic [7:0] seq [5];
    logic       has [5];
    ev_t e;
    seq = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    has = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    ev_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (has[i]) expect_ev(8'h75, 1'b1, (i == 4), 8'h00);
      send(seq[i]);
      checks++;
      if (has[i]) begin
        e = exp_q.pop_front();
        if ({ev_valid, ev_code, ev_ext, ev_release} !== {1'b1, e.code, e.ext, e.rel}) begin
          failures++;
          $display("FAIL ext_event[%0d]: got %h expected %h", i,
                   {ev_valid, ev_code, ev_ext, ev_release}, {1'b1, e.code, e.ext, e.rel});
        end
      end else if (ev_valid !== 1'b0) begin
        failures++;
        $display("FAIL ext_prefix[%0d]: got ev_valid=%b expected 0", i, ev_valid);
      end
    end
  endtask

  task automatic test_overflow();
    ev_t e;
    logic [7:0] b;
    do_reset();
    ev_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'h15 + 8'(i);
      if (i < DEPTH) expect_ev(b, 1'b0, 1'b0, 8'h00);
      send(b);
      if (i == DEPTH - 1) begin
        checks++;
        if (overflow !== 1'b0) begin
          failures++;
          $display("FAIL ovf_not_yet: got %b expected 0", overflow);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set: got %b expected 1", overflow);
    end
    checks++;
    if ({ev_valid, ev_code, ev_ext, ev_release} !== {1'b1, 8'h15, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL head_stable: got %h expected %h",
               {ev_valid, ev_code, ev_ext, ev_release}, {1'b1, 8'h15, 1'b0, 1'b0});
    end
    // Simultaneous push and pop while full.
    rx_data  = 8'h21;
    rx_valid = 1'b1;
    ev_ready = 1'b1;
    e = exp_q.pop_front();
    checks++;
    if ({ev_valid, ev_code} !== {1'b1, e.code}) begin
      failures++;
      $display("FAIL full_pushpop_head: got %h expected %h", {ev_valid, ev_code}, {1'b1, e.code});
    end
    expect_ev(8'h21, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rx_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      e = exp_q.pop_front();
      checks++;
      if ({ev_valid, ev_code, ev_ext, ev_release} !== {1'b1, e.code, e.ext, e.rel}) begin
        failures++;
        $display("FAIL drain[%0d]: got %h expected %h", i,
                 {ev_valid, ev_code, ev_ext, ev_release}, {1'b1, e.code, e.ext, e.rel});
      end
      @(negedge clk);
    end
    checks++;
    if (ev_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_empty: got ev_valid=%b expected 0", ev_valid);
    end
  endtask

  task automatic test_timeout();
    ev_t e;
    do_reset();
    ev_ready = 1'b1;
    send(8'hF0);
    repeat (TO - 2) @(negedge clk);
    expect_ev(8'h1C, 1'b0, 1'b1, 8'h00);
    send(8'h1C);
    e = exp_q.pop_front();
    checks++;
    if ({ev_valid, ev_code, ev_ext, ev_release} !== {1'b1, e.code, e.ext, e.rel}) begin
      failures++;
      $display("FAIL break_before_timeout: got %h expected %h",
               {ev_valid, ev_code, ev_ext, ev_release}, {1'b1, e.code, e.ext, e.rel});
    end
    send(8'hF0);
    repeat (TO - 1) @(negedge clk);
    expect_ev(8'h1C, 1'b0, 1'b0, 8'h00);
    send(8'h1C);
    e = exp_q.pop_front();
    checks++;
    if ({ev_valid, ev_code, ev_ext, ev_release} !== {1'b1, e.code, e.ext, e.rel}) begin
      failures++;
      $display("FAIL make_after_timeout: got %h expected %h",
               {ev_valid, ev_code, ev_ext, ev_release}, {1'b1, e.code, e.ext, e.rel});
    end
    send(8'hAA);
    checks++;
    if (ev_valid !== 1'b0) begin
      failures++;
      $display("FAIL aa_no_event: got ev_valid=%b expected 0", ev_valid);
    end
    send(8'hE0);
    send(8'hAA);
    expect_ev(8'h74, 1'b0, 1'b0, 8'h00);
    send(8'h74);
    e = exp_q.pop_front();
    checks++;
    if ({ev_valid, ev_code, ev_ext, ev_release} !== {1'b1, e.code, e.ext, e.rel}) begin
      failures++;
      $display("FAIL ctrl_clears_ext: got %h expected %h",
               {ev_valid, ev_code, ev_ext, ev_release}, {1'b1, e.code, e.ext, e.rel});
    end
  endtask

  task automatic test_reset_mid();
    ev_t e;
    do_reset();
    ev_ready = 1'b0;
    expect_ev(8'h12, 1'b0, 1'b0, 8'h00);
    send(8'h12);
    checks++;
    if ({ev_valid, ev_code, shift_held} !== {1'b1, exp_q[0].code, 1'b1}) begin
      failures++;
      $display("FAIL pre_reset_event: got %h expected %h",
               {ev_valid, ev_code, shift_held}, {1'b1, exp_q[0].code, 1'b1});
    end
    send(8'hE0);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ev_valid, ev_code, ev_ext, ev_release, shift_held, overflow} !== 13'h0) begin
      failures++;
      $display("FAIL during_reset: got %h expected 0000",
               {ev_valid, ev_code, ev_ext, ev_release, shift_held, overflow});
    end
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if ({ev_valid, ev_code, ev_ext, ev_release, shift_held, overflow} !== 13'h0) begin
      failures++;
      $display("FAIL after_reset: got %h expected 0000",
               {ev_valid, ev_code, ev_ext, ev_release, shift_held, overflow});
    end
    ev_ready = 1'b1;
    expect_ev(8'h74, 1'b0, 1'b0, 8'h00);
    send(8'h74);
    e = exp_q.pop_front();
    checks++;
    if ({ev_valid, ev_code, ev_ext, ev_release} !== {1'b1, e.code, e.ext, e.rel}) begin
      failures++;
      $display("FAIL post_reset_decode: got %h expected %h",
               {ev_valid, ev_code, ev_ext, ev_release}, {1'b1, e.code, e.ext, e.rel});
    end
  endtask

  task automatic test_shift();
    logic [7:0] seq [9];
    logic       held [9];
    seq  = '{8'h12, 8'h59, 8'hF0, 8'h12, 8'hF0, 8'h59, 8'hE0, 8'h12, 8'h59};
    held = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1};
    do_reset();
    ev_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send(seq[i]);
      if (seq[i] != 8'hF0 && seq[i] != 8'hE0) begin
        checks++;
        if (shift_held !== held[i]) begin
          failures++;
          $display("FAIL shift_held[%0d]: got %b expected %b", i, shift_held, held[i]);
        end
      end
    end
  endtask

`ifdef PS2_ASCII_EN
  task automatic test_ascii();
    logic [7:0] seq [5];
    logic       has [5];
    logic [7:0] asc [5];
    logic       held [5];
    ev_t e;
    seq  = '{8'h12, 8'h1C, 8'hF0, 8'h12, 8'h1C};
    has  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    asc  = '{8'h00, 8'h41, 8'h00, 8'h00, 8'h61};
    held = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    ev_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (has[i]) expect_ev(seq[i], 1'b0, (i == 3), asc[i]);
      send(seq[i]);
      if (has[i]) begin
        e = exp_q.pop_front();
        checks++;
        if ({ev_valid, ev_code, ev_release, ev_ascii, shift_held} !==
            {1'b1, e.code, e.rel, e.ascii, held[i]}) begin
          failures++;
          $display("FAIL ascii[%0d]: got %h expected %h", i,
                   {ev_valid, ev_code, ev_release, ev_ascii, shift_held},
                   {1'b1, e.code, e.rel, e.ascii, held[i]});
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_overflow();
    test_timeout();
    test_reset_mid();
    test_shift();
`ifdef PS2_ASCII_EN
    test_ascii();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
